mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one physical memory port between the pipeline's instruction-fetch requester (port a, read-only) and data-memory requester (port b, read/write).
- Sits between the pipelined datapath's two memory interfaces and the single memory/L2 interface.
- Serves one transaction at a time. The data side has priority, and a bounded-starvation counter guarantees forward progress for fetch.

Parameters:
- STARVE_LIMIT, 4, max consecutive D grants issued while I is waiting before I is forced; 0 = strict D priority.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  fetch read request, level-held until i_resp
- i_addr  in  32  fetch address
- i_rdata  out  32  fetch read data, valid when i_resp=1
- i_resp  out  1  fetch completion, one-cycle pulse
- d_read  in  1  data read request, level-held until d_resp
- d_write  in  1  data write request, level-held until d_resp
- d_wmask  in  4  byte write mask
- d_addr  in  32  data address
- d_wdata  in  32  data write data
- d_rdata  out  32  data read data, valid when d_resp=1
- d_resp  out  1  data completion, one-cycle pulse
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_wmask  out  4  memory byte mask
- pmem_addr  out  32  memory address
- pmem_wdata  out  32  memory write data
- pmem_rdata  in  32  memory read data
- pmem_resp  in  1  memory completion
- grant  out  2  current owner: 00 none, 01 I, 10 D

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; grant=0; all pmem_* outputs 0; i_resp=d_resp=0; rdata outputs 0; streak counter 0.
  - An in-flight memory transaction is abandoned; the memory is reset by the same rst_n.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE, arbitration at each rising edge:
  - d_req = d_read|d_write.
  - Only d_req -> SERVE_D. Only i_read -> SERVE_I. Neither -> stay in IDLE.
  - Both: if streak==STARVE_LIMIT -> SERVE_I, else SERVE_D.
- On the grant edge, latch the owner's addr, wmask, wdata and op into internal registers.
  - If d_read and d_write are both set, the op is a write (illegal combination; write wins).
  - I grants latch wmask=0 and op=read.
- SERVE_x:
  - pmem_read/pmem_write/pmem_addr/pmem_wmask/pmem_wdata are driven from the latched registers, constant for the whole state.
  - pmem_* outputs are 0 in IDLE.
  - Latency: a request sampled at edge N gives pmem strobe high in cycle N+1.
- Completion:
  - In the cycle pmem_resp=1, the owner's x_resp=1 and x_rdata=pmem_rdata, combinationally.
  - The next edge returns the FSM to IDLE.
  - The non-owner's resp is always 0.
- Requesters must drop or change their request after sampling resp.
  - IDLE re-arbitrates on the cycle after completion.
  - Minimum turnaround is therefore 1 dead cycle between transactions.
- pmem_resp while in IDLE is ignored: no resp pulses, no state change.
- Streak counter, width clog2(STARVE_LIMIT+1), minimum 1:
  - On a D grant with i_read=1: increment, saturating at STARVE_LIMIT.
  - On an I grant, or on any grant with i_read=0: clear to 0.
- Requests arriving or leaving mid-transaction do not affect the current owner. The owner is never pre-empted.
- i_rdata/d_rdata are 0 when the corresponding resp=0.
- grant mirrors the state: 01 in SERVE_I, 10 in SERVE_D, 00 in IDLE.

Test Plan:
- Reset mid-transaction: assert rst_n=0 during SERVE_D with pmem_write=1 -> pmem_write=0, grant=00 immediately (asynchronously); after release, the FSM is in IDLE with streak=0.
- Lone fetch: i_read=1, i_addr=0x60; memory responds 3 cycles after the strobe with rdata 0x00A00093 -> pmem_read=1, pmem_addr=0x60 from cycle N+1; i_resp=1 with i_rdata=0x00A00093 in the pmem_resp cycle; grant=00 on the next cycle.
- Data write: d_write=1, d_addr=0x100, d_wmask=0x3, d_wdata=0xDEADBEEF -> pmem_write=1, pmem_wmask=0x3, pmem_wdata=0xDEADBEEF held until resp; d_resp pulses exactly once; i_resp stays 0.
- Simultaneous requests: i_read and d_read both held from reset -> D is served first, then I on the next arbitration; inputs changed mid-transaction leave pmem_addr unchanged.
- Starvation bound: STARVE_LIMIT=4, i_read held, D re-requests immediately after each d_resp -> exactly 4 D grants, then 1 I grant, then D resumes with streak=0.
- Spurious response: pmem_resp=1 in IDLE with no requests -> i_resp=d_resp=0, grant stays 00.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Shares one memory port between instruction fetch (I) and data (D) requesters.
// D has priority; a streak counter forces an I grant after STARVE_LIMIT back-to-back D grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [3:0]  pmem_wmask,
    output logic [31:0] pmem_addr,
    output logic [31:0] pmem_wdata,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp,
    output logic [1:0]  grant
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nxt;
    logic          grant_i;
    logic          grant_d;
    logic          d_req;
    logic          force_i;

    logic          lat_read;
    logic          lat_write;
    logic [3:0]    lat_wmask;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;

    logic          serve_i;
    logic          serve_d;
    logic          busy;

    assign d_req   = d_read | d_write;
    // A limit of zero means D always wins a tie; fetch never gets forced.
    assign force_i = (STARVE_LIMIT != 0) && (streak == LIMIT);

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                grant_d = d_req && !(i_read && force_i);
                grant_i = i_read && !grant_d;
                if (grant_d) begin
                    state_nxt = SERVE_D;
                    if (i_read) begin
                        streak_nxt = (streak == LIMIT) ? streak : streak + SW'(1);
                    end else begin
                        streak_nxt = '0;
                    end
                end else if (grant_i) begin
                    state_nxt  = SERVE_I;
                    streak_nxt = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    // Transaction fields are captured once on the grant edge so the owner may change its inputs freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_wmask <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant_d) begin
            lat_read  <= d_read & ~d_write;
            lat_write <= d_write;
            lat_wmask <= d_wmask;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
        end else if (grant_i) begin
            lat_read  <= 1'b1;
            lat_write <= 1'b0;
            lat_wmask <= '0;
            lat_addr  <= i_addr;
            lat_wdata <= '0;
        end
    end

    assign serve_i = (state == SERVE_I);
    assign serve_d = (state == SERVE_D);
    assign busy    = serve_i | serve_d;

    assign pmem_read  = busy & lat_read;
    assign pmem_write = busy & lat_write;
    assign pmem_wmask = busy ? lat_wmask : 4'h0;
    assign pmem_addr  = busy ? lat_addr  : 32'h0;
    assign pmem_wdata = busy ? lat_wdata : 32'h0;

    assign i_resp  = serve_i & pmem_resp;
    assign d_resp  = serve_d & pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : 32'h0;
    assign d_rdata = d_resp ? pmem_rdata : 32'h0;

    assign grant = {serve_d, serve_i};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [3:0]  pmem_wmask;
    logic [31:0] pmem_addr;
    logic [31:0] pmem_wdata;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_wmask    (d_wmask),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_wmask (pmem_wmask),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of a granted cycle: checks owner/address, completes, and checks return to idle.
    task automatic serve(input string tag, input logic [1:0] exp_grant, input logic [31:0] exp_addr,
                         input logic [31:0] rdata);
        chk({tag, "_grant"}, {30'h0, grant}, {30'h0, exp_grant});
        chk({tag, "_addr"}, pmem_addr, exp_addr);
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        #1;
        if (exp_grant == 2'b10) begin
            chk({tag, "_d_resp"}, {31'h0, d_resp}, 32'h1);
            chk({tag, "_d_rdata"}, d_rdata, rdata);
            chk({tag, "_i_resp_quiet"}, {31'h0, i_resp}, 32'h0);
        end else begin
            chk({tag, "_i_resp"}, {31'h0, i_resp}, 32'h1);
            chk({tag, "_i_rdata"}, i_rdata, rdata);
            chk({tag, "_d_resp_quiet"}, {31'h0, d_resp}, 32'h0);
        end
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;
        #1;
        chk({tag, "_idle_grant"}, {30'h0, grant}, 32'h0);
        chk({tag, "_resp_once"}, {30'h0, d_resp, i_resp}, 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        i_read     = 1'b0;
        i_addr     = 32'h0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_wmask    = 4'h0;
        d_addr     = 32'h0;
        d_wdata    = 32'h0;
        pmem_rdata = 32'h0;
        pmem_resp  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_grant", {30'h0, grant}, 32'h0);
        chk("rst_pmem_strobes", {30'h0, pmem_read, pmem_write}, 32'h0);
        chk("rst_pmem_addr", pmem_addr, 32'h0);
        chk("rst_resps", {30'h0, i_resp, d_resp}, 32'h0);
        chk("rst_rdata", i_rdata | d_rdata, 32'h0);
        rst_n = 1'b1;

        // Spurious response while idle
        @(negedge clk);
        pmem_rdata = 32'h0000CAFE;
        pmem_resp  = 1'b1;
        #1;
        chk("spur_resps", {30'h0, i_resp, d_resp}, 32'h0);
        chk("spur_rdata", i_rdata | d_rdata, 32'h0);
        @(negedge clk);
        chk("spur_grant", {30'h0, grant}, 32'h0);
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;

        // Lone fetch, memory answers on the 4th strobe cycle
        i_read = 1'b1;
        i_addr = 32'h60;
        @(negedge clk);
        chk("fetch_pmem_read", {31'h0, pmem_read}, 32'h1);
        chk("fetch_pmem_write", {31'h0, pmem_write}, 32'h0);
        chk("fetch_pmem_wmask", {28'h0, pmem_wmask}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("fetch_hold_read", {31'h0, pmem_read}, 32'h1);
        end
        @(negedge clk);
        serve("fetch", 2'b01, 32'h60, 32'h00A00093);
        i_read = 1'b0;

        // Data write
        d_write = 1'b1;
        d_addr  = 32'h100;
        d_wmask = 4'h3;
        d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_pmem_write", {31'h0, pmem_write}, 32'h1);
        chk("wr_pmem_read", {31'h0, pmem_read}, 32'h0);
        chk("wr_pmem_wmask", {28'h0, pmem_wmask}, 32'h3);
        chk("wr_pmem_wdata", pmem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_hold_wdata", pmem_wdata, 32'hDEADBEEF);
        serve("wr", 2'b10, 32'h100, 32'h0);
        d_write = 1'b0;

        // Reset in the middle of a D write
        d_write = 1'b1;
        d_addr  = 32'h180;
        d_wmask = 4'hF;
        d_wdata = 32'h12345678;
        @(negedge clk);
        chk("mid_pre_write", {31'h0, pmem_write}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_write", {31'h0, pmem_write}, 32'h0);
        chk("mid_async_grant", {30'h0, grant}, 32'h0);
        chk("mid_async_addr", pmem_addr, 32'h0);

        // Simultaneous requests held through reset release: D first, then I
        d_write = 1'b0;
        d_read  = 1'b1;
        d_addr  = 32'h300;
        i_read  = 1'b1;
        i_addr  = 32'h200;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("sim_first_grant", {30'h0, grant}, 32'h2);
        chk("sim_pmem_read", {31'h0, pmem_read}, 32'h1);
        d_addr  = 32'h999;
        d_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("sim_addr_stable", pmem_addr, 32'h300);
        chk("sim_wdata_stable", pmem_wdata, 32'h12345678);
        serve("sim_d", 2'b10, 32'h300, 32'h00000055);
        d_read = 1'b0;
        @(negedge clk);
        serve("sim_i", 2'b01, 32'h200, 32'h00000066);

        // Starvation bound: 4 D grants then 1 I grant, twice (streak restarts from 0)
        d_read = 1'b1;
        d_addr = 32'h500;
        i_addr = 32'h400;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                serve($sformatf("starve_r%0d_d%0d", r, k), 2'b10, d_addr, 32'h1000 + k);
                d_addr = d_addr + 32'h4;
            end
            @(negedge clk);
            serve($sformatf("starve_r%0d_i", r), 2'b01, i_addr, 32'h2000 + r);
            i_addr = i_addr + 32'h4;
        end
        i_read = 1'b0;
        @(negedge clk);
        serve("starve_resume_d", 2'b10, d_addr, 32'h3000);
        d_read = 1'b0;
        @(negedge clk);
        chk("end_idle_grant", {30'h0, grant}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
